vend_txn_controller: RTL and testbench

Transaction sequencer for the vending machine datapath. It latches an item selection and its price, and arbitrates between two coin acceptors (slot A and slot B) feeding a single credit accumulator. It then sequences the dispense handshake to the motor driver and the change/refund payout handshake to the coin hopper. It sits between the front-panel/coin-acceptor logic and the dispense/hopper actuators.

---
 rtl/vend_txn_controller.sv | 155 +++++++++++++++
 tb/tb_vend_txn_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_txn_controller.sv
// rtl/vend_txn_controller.sv - vending transaction sequencer: selection, coin arbitration, dispense, payout
// Build option: define VEND_RR_ARB_EN for round-robin coin slot arbitration (fixed A priority otherwise).
module vend_txn_controller #(
  parameter int VAL_W       = 5,
  parameter int TIMEOUT_CYC = 64,
  parameter int COIN_UNIT   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       item_sel,
  input  logic             item_valid,
  input  logic [VAL_W-1:0] item_price,
  input  logic             coin_a_valid,
  input  logic [VAL_W-1:0] coin_a_val,
  output logic             coin_a_ready,
  input  logic             coin_b_valid,
  input  logic [VAL_W-1:0] coin_b_val,
  output logic             coin_b_ready,
  input  logic             cancel,
  output logic             disp_req,
  output logic [4:0]       disp_item,
  input  logic             disp_ack,
  output logic             chg_req,
  input  logic             chg_ack,
  output logic [VAL_W:0]   credit,
  output logic [VAL_W:0]   change,
  output logic             txn_done,
  output logic             short_pay,
  output logic [2:0]       state
);

  localparam int             TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [VAL_W:0] UNIT   = (VAL_W + 1)'(COIN_UNIT);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_DISPENSE = 3'd2,
    S_CHANGE   = 3'd3,
    S_REFUND   = 3'd4
  } state_t;

  state_t           st, st_nx;
  logic [VAL_W-1:0] price_q;
  logic [TW-1:0]    timer;
  logic             a_pri, acc_a, acc_b, sel_ok, coin_nz, in_collect, paying;
  logic [VAL_W:0]   coin_add, credit_post;

  assign in_collect = (st == S_COLLECT);
  assign paying     = (st == S_CHANGE) || (st == S_REFUND);

`ifdef VEND_RR_ARB_EN
  // last_b set means B took the previous coin, so A wins the next tie.
  logic last_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_b <= 1'b1;
    else if (acc_a || acc_b)
      last_b <= acc_b;
  end
  assign a_pri = last_b;
`else
  assign a_pri = 1'b1;
`endif

  assign coin_a_ready = in_collect && (!coin_b_valid || a_pri);
  assign coin_b_ready = in_collect && (!coin_a_valid || !a_pri);
  assign acc_a        = coin_a_valid && coin_a_ready;
  assign acc_b        = coin_b_valid && coin_b_ready;
  assign coin_add     = acc_a ? {1'b0, coin_a_val} : (acc_b ? {1'b0, coin_b_val} : '0);
  assign coin_nz      = |coin_add;
  assign credit_post  = credit + coin_add;
  assign sel_ok       = item_valid && (|item_price);

  assign state    = st;
  assign disp_req = (st == S_DISPENSE);
  assign chg_req  = paying && (change >= UNIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st <= S_IDLE;
    else
      st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:
        if (sel_ok)
          st_nx = S_COLLECT;
      S_COLLECT:
        if (cancel)
          st_nx = S_REFUND;
        else if (credit_post >= {1'b0, price_q})
          st_nx = S_DISPENSE;
        else if (!coin_nz && timer == T_LAST)
          st_nx = S_REFUND;
      S_DISPENSE:
        if (disp_ack)
          st_nx = (change == '0) ? S_IDLE : S_CHANGE;
      S_CHANGE, S_REFUND:
        if (change < UNIT)
          st_nx = S_IDLE;
      default:
        st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_item <= '0;
      price_q   <= '0;
      credit    <= '0;
      change    <= '0;
      timer     <= '0;
      txn_done  <= 1'b0;
      short_pay <= 1'b0;
    end else begin
      txn_done  <= 1'b0;
      short_pay <= 1'b0;
      case (st)
        S_IDLE:
          if (sel_ok) begin
            disp_item <= item_sel;
            price_q   <= item_price;
            credit    <= '0;
            timer     <= '0;
          end
        S_COLLECT: begin
          credit <= credit_post;
          timer  <= coin_nz ? '0 : timer + 1'b1;
          if (st_nx == S_REFUND)
            change <= credit_post;
          else if (st_nx == S_DISPENSE)
            change <= credit_post - {1'b0, price_q};
        end
        S_DISPENSE:
          if (disp_ack && change == '0)
            txn_done <= 1'b1;
        S_CHANGE, S_REFUND:
          if (change < UNIT) begin
            txn_done  <= 1'b1;
            short_pay <= (change != '0);
            change    <= '0;
          end else if (chg_ack) begin
            change <= change - UNIT;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// tb/tb_vend_txn_controller.sv - directed table-driven bench for vend_txn_controller
module tb_vend_txn_controller;

`ifdef VEND_RR_ARB_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] item_sel, item_price, coin_a_val, coin_b_val, disp_item;
  logic       item_valid, coin_a_valid, coin_a_ready, coin_b_valid, coin_b_ready;
  logic       cancel, disp_req, disp_ack, chg_req, chg_ack, txn_done, short_pay;
  logic [5:0] credit, change;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int disp_cycles = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (disp_req) disp_cycles++;

  vend_txn_controller dut (
    .clk(clk), .rst_n(rst_n),
    .item_sel(item_sel), .item_valid(item_valid), .item_price(item_price),
    .coin_a_valid(coin_a_valid), .coin_a_val(coin_a_val), .coin_a_ready(coin_a_ready),
    .coin_b_valid(coin_b_valid), .coin_b_val(coin_b_val), .coin_b_ready(coin_b_ready),
    .cancel(cancel), .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit), .change(change),
    .txn_done(txn_done), .short_pay(short_pay), .state(state)
  );

  typedef struct {
    string      tag;
    logic       iv;
    logic [4:0] isel, iprice;
    logic       av;
    logic [4:0] aval;
    logic       bv;
    logic [4:0] bval;
    logic       cn, dack, cack;
    logic [2:0] e_st;
    logic [4:0] e_item;
    logic [5:0] e_cr, e_ch;
    logic       e_dreq, e_creq, e_done, e_short, e_aa, e_ab;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string tag, int iv, int isel, int ip, int av, int aval, int bv, int bval,
                              int cn, int da, int ca, int est, int eitem, int ecr, int ech,
                              int edr, int ecq, int edn, int esh, int eaa, int eab);
    vec_t v;
    v.tag = tag; v.iv = 1'(iv); v.isel = 5'(isel); v.iprice = 5'(ip);
    v.av = 1'(av); v.aval = 5'(aval); v.bv = 1'(bv); v.bval = 5'(bval);
    v.cn = 1'(cn); v.dack = 1'(da); v.cack = 1'(ca);
    v.e_st = 3'(est); v.e_item = 5'(eitem); v.e_cr = 6'(ecr); v.e_ch = 6'(ech);
    v.e_dreq = 1'(edr); v.e_creq = 1'(ecq); v.e_done = 1'(edn); v.e_short = 1'(esh);
    v.e_aa = 1'(eaa); v.e_ab = 1'(eab);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    item_valid = 0; item_sel = 0; item_price = 0;
    coin_a_valid = 0; coin_a_val = 0; coin_b_valid = 0; coin_b_val = 0;
    cancel = 0; disp_ack = 0; chg_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc_a, acc_b;
    logic [25:0] act, exp;
    int n, d0;

    //           tag        iv sel pr  av av_v bv bv_v cn da ca  st itm cr ch  dr cq dn sh aa ab
    vecs.push_back(mk("t2_sel",   1, 7, 20, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t2_tie1",  0, 0, 0, 1, 5, 1, 5, 0, 0, 0, 1, 7, 5, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t2_tie2",  0, 0, 0, 1, 5, 1, 5, 0, 0, 0, 1, 7, 10, 0, 0, 0, 0, 0, RR ? 0 : 1, RR ? 1 : 0));
    vecs.push_back(mk("t2_tie3",  0, 0, 0, 1, 5, 1, 5, 0, 0, 0, 1, 7, 15, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t2_tie4",  0, 0, 0, 1, 5, 1, 5, 0, 0, 0, 2, 7, 20, 0, 1, 0, 0, 0, RR ? 0 : 1, RR ? 1 : 0));
    vecs.push_back(mk("t2_dack",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 20, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 20, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_sel",   1, 4, 15, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_a10",   0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 1, 4, 10, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t1_a10b",  0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 2, 4, 20, 5, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t1_hold",  0, 0, 0, 1, 10, 0, 0, 1, 0, 0, 2, 4, 20, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_dack",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 4, 20, 5, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t1_cack",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 4, 20, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 20, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t1_stray", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4, 20, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_sel",   1, 2, 12, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_a20",   0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 2, 2, 20, 8, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t5_dack",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 2, 20, 8, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t5_cack",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 2, 20, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t5_short", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 20, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("zero_prc", 1, 11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 20, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_sel",   1, 9, 20, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_a10",   1, 3, 5, 1, 10, 0, 0, 0, 0, 0, 1, 9, 10, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t4_cxl",   0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 4, 9, 15, 15, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("t4_p1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 9, 15, 10, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t4_p2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 9, 15, 5, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t4_p3",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 9, 15, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 15, 0, 0, 0, 1, 0, 0, 0));

    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {state, disp_item, credit, change, disp_req, chg_req, txn_done, short_pay,
                          coin_a_ready, coin_b_ready}, '0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      item_valid = vecs[i].iv; item_sel = vecs[i].isel; item_price = vecs[i].iprice;
      coin_a_valid = vecs[i].av; coin_a_val = vecs[i].aval;
      coin_b_valid = vecs[i].bv; coin_b_val = vecs[i].bval;
      cancel = vecs[i].cn; disp_ack = vecs[i].dack; chg_ack = vecs[i].cack;
      #2;
      acc_a = coin_a_valid & coin_a_ready;
      acc_b = coin_b_valid & coin_b_ready;
      @(posedge clk);
      #1;
      act = {state, disp_item, credit, change, disp_req, chg_req, txn_done, short_pay, acc_a, acc_b};
      exp = {vecs[i].e_st, vecs[i].e_item, vecs[i].e_cr, vecs[i].e_ch, vecs[i].e_dreq, vecs[i].e_creq,
             vecs[i].e_done, vecs[i].e_short, vecs[i].e_aa, vecs[i].e_ab};
      chk(vecs[i].tag, act, exp);
    end
    @(negedge clk);
    clear_inputs();

    // Timeout: 64 silent cycles after the last nonzero coin; a zero coin does not restart the count.
    @(negedge clk);
    item_valid = 1; item_sel = 3; item_price = 20;
    @(negedge clk);
    item_valid = 0;
    chk("t3_collect", state, 3'd1);
    coin_a_valid = 1; coin_a_val = 10;
    @(posedge clk);
    #1;
    chk("t3_credit", credit, 6'd10);
    coin_a_valid = 0;
    d0 = disp_cycles;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20) begin coin_a_valid = 1; coin_a_val = 0; end
      if (n == 21) coin_a_valid = 0;
      if (state == 3'd4) break;
    end
    chk("t3_timeout_cycles", n, 64);
    chk("t3_refund", {state, credit, change}, {3'd4, 6'd10, 6'd10});
    chg_ack = 1;
    @(posedge clk);
    #1;
    chk("t3_pay1", change, 6'd5);
    @(posedge clk);
    #1;
    chk("t3_pay2", {change, chg_req}, {6'd0, 1'b0});
    chg_ack = 0;
    @(posedge clk);
    #1;
    chk("t3_done", {state, txn_done, short_pay}, {3'd0, 1'b1, 1'b0});
    chk("t3_no_disp", disp_cycles - d0, 0);

    // Asynchronous reset during DISPENSE, then coins are refused until a new selection.
    @(negedge clk);
    item_valid = 1; item_sel = 6; item_price = 10;
    @(negedge clk);
    item_valid = 0; coin_a_valid = 1; coin_a_val = 10;
    @(negedge clk);
    coin_a_valid = 0;
    chk("t6_dispense", {state, disp_req}, {3'd2, 1'b1});
    #2;
    rst_n = 0;
    #1;
    chk("t6_async_reset", {state, disp_req, chg_req, credit, change, disp_item}, '0);
    @(negedge clk);
    rst_n = 1;
    coin_a_valid = 1; coin_a_val = 10;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_accept", {state, credit, change, coin_a_ready, chg_req}, '0);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
